// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/response and data-memory bus of the LSU
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [3:0]  req_type;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic        MemReadEn;
  logic        MemWriteEn;
  logic [3:0]  loadtype;
  logic [3:0]  storetype;
  logic [63:0] AddressBus;
  logic [63:0] DataMemoryInput;
  logic [63:0] DataMemoryOutput;
  modport slave (
    input  req_valid, req_is_store, req_type, req_addr, req_wdata, req_rd, resp_ready, DataMemoryOutput,
    output req_ready, resp_valid, resp_data, resp_rd, resp_err,
           MemReadEn, MemWriteEn, loadtype, storetype, AddressBus, DataMemoryInput
  );
  modport master (
    output req_valid, req_is_store, req_type, req_addr, req_wdata, req_rd, resp_ready, DataMemoryOutput,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_err,
           MemReadEn, MemWriteEn, loadtype, storetype, AddressBus, DataMemoryInput
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit with fault checking in front of a data memory
`ifndef MEMORY_BITS
`define MEMORY_BITS 16
`endif
module load_store_unit #(
  parameter int MEM_BITS = `MEMORY_BITS
) (
  input logic              clock,
  input logic              rst,
  load_store_unit_if.slave bus
);
  localparam logic [3:0] LD_H = 4'd1, LD_W = 4'd2, LD_D = 4'd3, LD_HU = 4'd5;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_is_store;
  logic [3:0]  r_type;
  logic [63:0] r_addr, r_wdata, r_data;
  logic [4:0]  r_rd;
  logic [1:0]  r_err;
  logic        w_acc, w_illegal, w_oor, w_mis, w_iss;
  logic [1:0]  w_size, w_err;
  // fault classification of the incoming request, highest priority first
  always_comb begin
    w_acc     = bus.req_valid && bus.req_ready;
    w_illegal = bus.req_is_store ? (bus.req_type > 4'd3) : (bus.req_type > 4'd5);
    w_oor     = (bus.req_addr >> MEM_BITS) != 64'd0;
    w_size    = bus.req_is_store ? bus.req_type[1:0] :
                (bus.req_type == LD_D) ? 2'd3 :
                (bus.req_type == LD_W) ? 2'd2 :
                (bus.req_type == LD_H || bus.req_type == LD_HU) ? 2'd1 : 2'd0;
    w_mis     = (w_size == 2'd1 && bus.req_addr[0]) ||
                (w_size == 2'd2 && bus.req_addr[1:0] != 2'd0) ||
                (w_size == 2'd3 && bus.req_addr[2:0] != 3'd0);
    w_err     = w_illegal ? 2'b10 : w_oor ? 2'b11 : w_mis ? 2'b01 : 2'b00;
  end
  // next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? ((w_err != 2'b00) ? RESP : ISSUE) : IDLE;
      ISSUE:   w_next = r_is_store ? RESP : WAIT;
      WAIT:    w_next = RESP;
      default: w_next = bus.resp_ready ? IDLE : RESP;
    endcase
  end
  // state register
  always_ff @(posedge clock) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // request capture on accept, load data capture in WAIT
  always_ff @(posedge clock) begin
    if (rst) begin
      r_is_store <= 1'b0;
      r_type     <= 4'd0;
      r_addr     <= 64'd0;
      r_wdata    <= 64'd0;
      r_rd       <= 5'd0;
      r_err      <= 2'b00;
      r_data     <= 64'd0;
    end else if (w_acc) begin
      r_is_store <= bus.req_is_store;
      r_type     <= bus.req_type;
      r_addr     <= bus.req_addr;
      r_wdata    <= bus.req_wdata;
      r_rd       <= bus.req_rd;
      r_err      <= w_err;
      r_data     <= 64'd0;
    end else if (r_state == WAIT) begin
      r_data     <= bus.DataMemoryOutput;
    end
  end
  // memory bus is live only in ISSUE and is forced quiet while rst is high
  always_comb begin
    w_iss               = (r_state == ISSUE) && !rst;
    bus.req_ready       = (r_state == IDLE) && !rst;
    bus.MemReadEn       = w_iss && !r_is_store;
    bus.MemWriteEn      = w_iss && r_is_store;
    bus.AddressBus      = w_iss ? r_addr : 64'd0;
    bus.DataMemoryInput = w_iss ? r_wdata : 64'd0;
    bus.loadtype        = w_iss ? r_type : 4'd0;
    bus.storetype       = w_iss ? r_type : 4'd0;
    bus.resp_valid      = (r_state == RESP);
    bus.resp_data       = r_data;
    bus.resp_rd         = r_rd;
    bus.resp_err        = r_err;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with a response scoreboard and a byte-array data memory
module tb_load_store_unit;
  localparam int MB = 12;
  localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LD = 4'd3, LBU = 4'd4;
  localparam logic [3:0] SB = 4'd0, SH = 4'd1, SW = 4'd2, SD = 4'd3;
  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic [1:0]  err;
    int          lat;
    logic        en;
    int          hold;
  } exp_t;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic [7:0] mem [0:(1<<MB)-1];
  exp_t q[$];
  int vectors = 0;
  int errors = 0;
  int done = 0;
  load_store_unit_if bus();
  load_store_unit #(.MEM_BITS(MB)) dut (.clock(clock), .rst(rst), .bus(bus));
  always #5 clock = ~clock;
  function automatic logic [63:0] ld(logic [3:0] t, logic [MB-1:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i+:8] = mem[a + MB'(i)];
    case (t)
      LB:      return {{56{v[7]}}, v[7:0]};
      LH:      return {{48{v[15]}}, v[15:0]};
      LW:      return {{32{v[31]}}, v[31:0]};
      LBU:     return {56'd0, v[7:0]};
      4'd5:    return {48'd0, v[15:0]};
      default: return v;
    endcase
  endfunction
  // behavioural data memory: byte writes by store size, registered extended reads
  always @(posedge clock) begin
    if (bus.MemWriteEn)
      for (int i = 0; i < (1 << bus.storetype[1:0]); i++)
        mem[bus.AddressBus[MB-1:0] + MB'(i)] <= bus.DataMemoryInput[8*i+:8];
    if (bus.MemReadEn) bus.DataMemoryOutput <= ld(bus.loadtype, bus.AddressBus[MB-1:0]);
  end
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(bit st, logic [3:0] t, logic [63:0] a, logic [63:0] wd, logic [4:0] rd);
    int n = 0;
    @(posedge clock); #1;
    bus.req_is_store = st;
    bus.req_type = t;
    bus.req_addr = a;
    bus.req_wdata = wd;
    bus.req_rd = rd;
    bus.req_valid = 1'b1;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.req_ready && n < 20);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask
  task automatic issue(bit st, logic [3:0] t, logic [63:0] a, logic [63:0] wd, logic [4:0] rd,
                       logic [63:0] ed, logic [1:0] ee, int el, int hold);
    exp_t e;
    int d0 = done;
    e = '{ed, rd, ee, el, (ee == 2'b00), hold};
    q.push_back(e);
    send(st, t, a, wd, rd);
    for (int i = 0; i < 60 && done == d0; i++) @(negedge clock);
    if (done == d0) begin
      vectors++;
      errors++;
      $display("FAIL timeout: rd %0d got no response, expected one within 60 cycles", rd);
    end
  endtask
  // monitor: measures latency, pops the scoreboard on each response, checks hold stability
  initial begin
    exp_t cur;
    bit acc = 0, busy = 0, inresp = 0, chkidle = 0, en_seen = 0;
    int lat = 0, hold = 0;
    bus.resp_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (chkidle) begin
        chk("idle_ready", 64'(bus.req_ready), 64'd1);
        chk("idle_valid", 64'(bus.resp_valid), 64'd0);
        chkidle = 0;
        busy = 0;
        done++;
      end
      if (acc) begin
        busy = 1;
        lat = 1;
        en_seen = 0;
      end else if (busy) lat++;
      if (rst) begin
        busy = 0;
        inresp = 0;
      end
      acc = bus.req_valid && bus.req_ready && !rst;
      if (busy) begin
        en_seen |= bus.MemReadEn | bus.MemWriteEn;
        if (!inresp && bus.resp_valid) begin
          if (q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_resp: got rd %0d, expected no response", bus.resp_rd);
          end else begin
            cur = q.pop_front();
            inresp = 1;
            chk("latency", 64'(lat), 64'(cur.lat));
            chk("data", bus.resp_data, cur.data);
            chk("rd", 64'(bus.resp_rd), 64'(cur.rd));
            chk("err", 64'(bus.resp_err), 64'(cur.err));
            chk("mem_enable_seen", 64'(en_seen), 64'(cur.en));
            hold = cur.hold;
            if (hold > 0) bus.resp_ready = 1'b0;
          end
        end else if (inresp) begin
          chk("hold_valid", 64'(bus.resp_valid), 64'd1);
          chk("hold_data", bus.resp_data, cur.data);
          chk("hold_rd", 64'(bus.resp_rd), 64'(cur.rd));
          chk("hold_ready", 64'(bus.req_ready), 64'd0);
          if (hold > 0) hold--;
          if (hold == 0) bus.resp_ready = 1'b1;
        end else begin
          chk("busy_ready", 64'(bus.req_ready), 64'd0);
        end
        if (inresp && bus.resp_ready) begin
          inresp = 0;
          chkidle = 1;
        end
      end
    end
  end
  // stimulus
  initial begin
    bus.req_valid = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_type = 4'd0;
    bus.req_addr = 64'd0;
    bus.req_wdata = 64'd0;
    bus.req_rd = 5'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_valid", 64'(bus.resp_valid), 64'd0);
    chk("reset_rden", 64'(bus.MemReadEn), 64'd0);
    chk("reset_data", bus.resp_data, 64'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    chk("post_reset_ready", 64'(bus.req_ready), 64'd1);
    issue(1, SD, 64'h10, 64'h1122334455667788, 5'd1, 64'd0, 2'b00, 2, 0);
    issue(0, LD, 64'h10, 64'd0, 5'd2, 64'h1122334455667788, 2'b00, 3, 0);
    issue(1, SB, 64'h21, 64'h1234567890ABCD80, 5'd3, 64'd0, 2'b00, 2, 0);
    issue(0, LB, 64'h21, 64'd0, 5'd4, 64'hFFFFFFFFFFFFFF80, 2'b00, 3, 0);
    issue(0, LBU, 64'h21, 64'd0, 5'd5, 64'h0000000000000080, 2'b00, 3, 0);
    issue(0, LW, 64'h22, 64'd0, 5'd6, 64'd0, 2'b01, 1, 0);
    issue(0, LD, 64'h1000, 64'd0, 5'd7, 64'd0, 2'b11, 1, 0);
    issue(0, 4'hF, 64'h10, 64'd0, 5'd8, 64'd0, 2'b10, 1, 0);
    issue(1, 4'd4, 64'h1001, 64'd0, 5'd11, 64'd0, 2'b10, 1, 0);
    issue(1, SW, 64'h1002, 64'd0, 5'd12, 64'd0, 2'b11, 1, 0);
    issue(1, SH, 64'h11, 64'd0, 5'd13, 64'd0, 2'b01, 1, 0);
    issue(0, LH, 64'h10, 64'd0, 5'd9, 64'h0000000000007788, 2'b00, 3, 5);
    issue(1, SD, 64'h40, 64'h0102030405060708, 5'd10, 64'd0, 2'b00, 2, 0);
    send(1, SD, 64'h40, 64'hAAAAAAAAAAAAAAAA, 5'd14);
    rst = 1'b1;
    @(negedge clock);
    chk("rst_issue_we", 64'(bus.MemWriteEn), 64'd0);
    chk("rst_issue_addr", bus.AddressBus, 64'd0);
    chk("rst_issue_wdata", bus.DataMemoryInput, 64'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    chk("rst_after_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_after_ready", 64'(bus.req_ready), 64'd1);
    issue(0, LD, 64'h40, 64'd0, 5'd15, 64'h0102030405060708, 2'b00, 3, 0);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_BITS, default `MEMORY_BITS, is the number of low address bits decoded by the data memory.
REQ-002 Port clock, input, 1, the only clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1; reset is synchronous and active-high.
REQ-004 Port req_valid, input, 1, the pipeline presents a memory request.
REQ-005 Port req_ready, output, 1, the LSU accepts a request this cycle.
REQ-006 Port req_is_store, input, 1: 1 = store, 0 = load.
REQ-007 Port req_type, input, 4, carries a `LOAD_* code (load) or a `STORE_* code (store) from defs.h.
REQ-008 Port req_addr, input, 64, byte address.
REQ-009 Port req_wdata, input, 64, store data, least-significant bytes first.
REQ-010 Port req_rd, input, 5, destination tag, returned unchanged.
REQ-011 Port resp_valid, output, 1, the response is valid.
REQ-012 Port resp_ready, input, 1, the consumer accepts the response.
REQ-013 Port resp_data, output, 64, load result; 0 for stores and faults.
REQ-014 Port resp_rd, output, 5, the tag of the completed request.
REQ-015 Port resp_err, output, 2: 00 ok, 01 misaligned, 10 illegal type, 11 out of range.
REQ-016 Port MemReadEn, output, 1, data memory read enable.
REQ-017 Port MemWriteEn, output, 1, data memory write enable.
REQ-018 Port loadtype, output, 4, data memory load type.
REQ-019 Port storetype, output, 4, data memory store type.
REQ-020 Port AddressBus, output, 64, data memory address.
REQ-021 Port DataMemoryInput, output, 64, data memory write data.
REQ-022 Port DataMemoryOutput, input, 64, registered read data from the data memory, valid the cycle after a read-enabled edge.

Function
REQ-023 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; a single request is outstanding at most.
REQ-024 req_ready SHALL equal (state==IDLE && !rst); acceptance is the edge with req_valid && req_ready, and at that edge all req_* fields are registered.
REQ-025 On acceptance the fault check SHALL be performed in priority order:
- illegal type (10): a load code outside the six `LOAD_* codes, or a store code outside the four `STORE_* codes;
- out of range (11): req_addr[63:MEM_BITS] != 0;
- misaligned (01): halfword addr[0] != 0, word addr[1:0] != 0, doubleword addr[2:0] != 0.
REQ-026 A faulting request SHALL go IDLE->RESP with resp_data=0 and no memory enable ever asserted.
REQ-027 A non-faulting request SHALL go IDLE->ISSUE.
REQ-028 In ISSUE, AddressBus, DataMemoryInput, loadtype and storetype SHALL be driven from the registered request.
REQ-029 In ISSUE, exactly one of MemReadEn or MemWriteEn SHALL be 1, gated with !rst.
REQ-030 In every state other than ISSUE, both enables SHALL be 0.
REQ-031 Load: ISSUE->WAIT. In WAIT, DataMemoryOutput SHALL be captured into resp_data at the edge, then WAIT->RESP.
REQ-032 Store: ISSUE->RESP with resp_data=0.
REQ-033 Latency from the accept edge to resp_valid high SHALL be: load 3 cycles, store 2 cycles, fault 1 cycle.
REQ-034 In RESP, resp_valid=1 and resp_data, resp_rd and resp_err SHALL be held stable until the edge with resp_ready=1, then RESP->IDLE.
REQ-035 resp_valid SHALL be 0 in all states except RESP.
REQ-036 Load data SHALL pass through unmodified, since extension is done by the memory. Store data SHALL NOT be shifted.
REQ-037 req_ready SHALL be 0 from acceptance until the cycle after the response handshake; no request is accepted in the same cycle as a response completes.

Reset
REQ-038 rst=1 at an edge SHALL force IDLE and set resp_valid, resp_data, resp_rd, resp_err and the registered request to 0.
REQ-039 With rst=1, MemReadEn, MemWriteEn, AddressBus, DataMemoryInput, loadtype and storetype SHALL be 0 combinationally, so no memory write occurs at a reset edge, even mid-ISSUE.
REQ-040 A response pending at reset SHALL be discarded.

Verification
REQ-041 The bench SHALL cover: SD 0x1122334455667788 @0x10, then LD @0x10 -> resp_data=0x1122334455667788, err=00, resp_valid 3 cycles after accept.
REQ-042 The bench SHALL cover: SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFFFFFFFFFF80, then LBU @0x21 -> 0x0000000000000080.
REQ-043 The bench SHALL cover: LW @0x22 -> err=01, resp_data=0, resp_valid 1 cycle after accept, MemReadEn never 1.
REQ-044 The bench SHALL cover: LD @(1<<MEM_BITS) -> err=11; req_type=0xF load -> err=10; no memory enable in either case.
REQ-045 The bench SHALL cover: load completes with resp_ready=0 for 5 cycles -> resp_valid, resp_data and resp_rd stable and req_ready=0 throughout; IDLE one cycle after resp_ready=1.
REQ-046 The bench SHALL cover: rst=1 during ISSUE of SD 0xAA..AA @0x40 -> MemWriteEn=0 at that edge, memory @0x40 unchanged, state IDLE, resp_valid=0, req_ready=1 next cycle.
